// File: rtl/rv_core_pkg.sv
// Shared core definitions: data width, fetch reset address and the
// fetch-entry layout carried from the fetch queue to decode.
package rv_core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // One buffered instruction: the address it was fetched from and the word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Small synchronous FIFO: registered write, combinational head read,
// flush that clears occupancy and overrides push/pop in the same cycle.
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    // Empty head reads as zero so consumers never see stale storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Upstream credit must prevent a push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && full && !do_pop));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues in-order imem reads under a credit
// limit, buffers returned words with their pc, and discards words that were
// in flight when a redirect arrived.
module if_fetch_queue
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = rv_core_pkg::RESET_PC,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] tag_cnt;
    logic             inst_empty;
    logic             tag_empty;
    logic [31:0]      tag_pc;
    logic             req_fire;
    logic             rsp_keep;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Credit counts both buffered and in-flight words (including ones to be
    // dropped) so a kept response always finds room. Reset is folded in so the
    // request is withdrawn the instant reset asserts.
    assign req_valid = rst_n && !redirect_valid &&
                       (({1'b0, inst_cnt} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH));
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;
    assign rsp_keep  = rsp_valid && (drop == '0) && !redirect_valid;

    // Assemble the FIFO entry from the pc recorded at request time.
    always_comb begin
        wr_entry      = '0;
        wr_entry.pc   = tag_pc;
        wr_entry.inst = rsp_data;
    end

    // PCs of non-stale in-flight requests, oldest first.
    sync_fifo #(.W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (req_fire),
        .din   (fetch_pc),
        .pop   (rsp_keep),
        .dout  (tag_pc),
        .count (tag_cnt),
        .empty (tag_empty)
    );

    // Returned instructions awaiting decode.
    sync_fifo #(.W(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_inst_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .din   (wr_entry),
        .pop   (inst_valid && inst_ready),
        .dout  (head),
        .count (inst_cnt),
        .empty (inst_empty)
    );

    assign inst_valid = !inst_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    // Fetch pointer, in-flight count and stale-word drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (redirect_valid)  fetch_pc <= redirect_pc & ~32'h3;
            else if (req_fire)   fetch_pc <= fetch_pc + 32'd4;

            case ({req_fire, rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // Every word still in flight at a redirect is older than the new
            // target; a response landing in the redirect cycle is already gone.
            if (redirect_valid)
                drop <= outstanding - {{(CNT_W-1){1'b0}}, rsp_valid};
            else if (rsp_valid && (drop != '0))
                drop <= drop - 1'b1;
        end
    end

    // A kept response must have a recorded pc; tags never exceed in-flight words.
    a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !tag_empty);
    a_tag_bound: assert property (@(posedge clk) disable iff (!rst_n)
        tag_cnt <= outstanding);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus a random phase, checked
// every cycle against an epoch-based reference of the fetch stream.
module tb_if_fetch_queue;
    import rv_core_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } flight_t;

    // Reference: words in flight carry the redirect epoch they were issued in;
    // a word whose epoch is no longer current is simply discarded on return.
    flight_t      inflight[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t delivered[$];
    logic [31:0]  acc_log[$];
    logic [31:0]  mpc;
    int           epoch;
    int           cyc;
    int           lat;
    int           n_tests;
    int           n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive imem response, check outputs, advance the model.
    task automatic step();
        logic    m_req_valid;
        flight_t f;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = inflight[0].data;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #3;
        m_req_valid = !redirect_valid && ((exp_q.size() + inflight.size()) < DEPTH);
        chk("req_valid", {31'b0, req_valid}, {31'b0, m_req_valid});
        if (m_req_valid) chk("req_addr", req_addr, mpc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("inst_pc", inst_pc, exp_q[0].pc);
            chk("inst_data", inst_data, exp_q[0].inst);
        end
        if (exp_q.size() != 0 && inst_ready && !redirect_valid)
            delivered.push_back(exp_q.pop_front());
        if (rsp_valid) begin
            f = inflight.pop_front();
            if (f.epoch == epoch) exp_q.push_back('{pc: f.addr, inst: f.data});
        end
        if (m_req_valid && req_ready) begin
            inflight.push_back('{addr: mpc, data: $urandom, epoch: epoch, due: cyc + lat});
            acc_log.push_back(mpc);
            mpc = mpc + 32'd4;
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            mpc = redirect_pc & ~32'h3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset entered mid-cycle; outputs must drop at once.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_valid      = 1'b0;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("rst_req_valid",  {31'b0, req_valid},  32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_data",  inst_data, 32'd0);
        chk("rst_inst_pc",    inst_pc,   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inflight.delete();
        exp_q.delete();
        delivered.delete();
        acc_log.delete();
        mpc = RESET_PC;
        chk("rst_req_addr", req_addr, RESET_PC);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1;
        mpc = RESET_PC;
        rsp_data = '0;
        do_reset();

        // Streaming at full rate, latency 1.
        req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        repeat (10) step();
        chk("stream_a0", acc_log[0], 32'h0);
        chk("stream_a1", acc_log[1], 32'h4);
        chk("stream_a2", acc_log[2], 32'h8);
        chk("stream_d0", delivered[0].pc, 32'h0);

        // Decode stalled: credit stops issue at DEPTH, then resumes at 0x10.
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b0; lat = 1;
        repeat (10) step();
        chk("stall_count", acc_log.size(), DEPTH);
        chk("stall_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (6) step();
        chk("stall_resume", acc_log[4], 32'h10);

        // Redirect with two words in flight at latency 3.
        do_reset();
        inst_ready = 1'b1; lat = 3;
        req_ready = 1'b1;
        repeat (2) step();
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0; req_ready = 1'b1;
        repeat (12) step();
        chk("redir_addr", acc_log[2], 32'h100);
        chk("redir_first", delivered[0].pc, 32'h100);

        // Redirect coinciding with a response, one more word in flight.
        do_reset();
        inst_ready = 1'b1; lat = 2;
        req_ready = 1'b1;
        repeat (2) step();
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        chk("same_cyc_none", delivered.size(), 0);
        req_ready = 1'b1;
        repeat (6) step();
        chk("same_cyc_first", delivered[0].pc, 32'h200);

        // Redirect to the top word: address wraps to zero.
        do_reset();
        inst_ready = 1'b1; req_ready = 1'b1; lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        chk("wrap_a0", acc_log[0], 32'hFFFF_FFFC);
        chk("wrap_a1", acc_log[1], 32'h0);
        chk("wrap_d0", delivered[0].pc, 32'hFFFF_FFFC);
        chk("wrap_d1", delivered[1].pc, 32'h0);

        // Reset with three words buffered.
        do_reset();
        inst_ready = 1'b0; req_ready = 1'b1; lat = 1;
        for (int i = 0; i < 20 && exp_q.size() < 3; i++) step();
        chk("fill3", exp_q.size(), 3);
        chk("fill3_valid", {31'b0, inst_valid}, 32'd1);
        do_reset();
        inst_ready = 1'b1; req_ready = 1'b1;
        repeat (3) step();

        // Random traffic, latencies and redirects (some misaligned).
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            lat            = $urandom_range(1, 3);
            step();
        end
        redirect_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
